// File: rtl/xbus_arbiter_if.sv
// Xbus backplane arbitration signals: active-low open-collector request/busy
// lines from the masters and the registered grant/status outputs of the arbiter.
interface xbus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] req_n;
  logic            busy_n;
  logic [NREQ-1:0] grant_n;
  logic [IDW-1:0]  owner;
  logic            owner_valid;
  logic            timeout;

  modport master (
    output req_n, busy_n,
    input  grant_n, owner, owner_valid, timeout
  );

  modport slave (
    input  req_n, busy_n,
    output grant_n, owner, owner_valid, timeout
  );
endinterface

// File: rtl/xbus_arbiter.sv
// Round-robin arbiter for the Xbus open-collector request/busy lines: one
// active-low grant at a time, ack timeout on unused grants, hold-timeout flag.
module xbus_arbiter #(
  parameter int NREQ         = 4,
  parameter int IDW          = 2,
  parameter int CW           = 8,
  parameter int ACK_TIMEOUT  = 8,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  xbus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BUSY, ST_RELEASE} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] req_meta_q, req_s_q;
  logic            busy_meta_q, busy_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [NREQ-1:0] grant_n_q, grant_n_d;
  logic            owner_valid_q, owner_valid_d;
  logic            timeout_q, timeout_d;

  logic [NREQ-1:0] rq;
  logic            bsy;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic            any_req;

  // Backplane lines are asynchronous; idle level of a pulled-up line is 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_meta_q  <= '1;
      req_s_q     <= '1;
      busy_meta_q <= 1'b1;
      busy_s_q    <= 1'b1;
    end else begin
      req_meta_q  <= bus.req_n;
      req_s_q     <= req_meta_q;
      busy_meta_q <= bus.busy_n;
      busy_s_q    <= busy_meta_q;
    end
  end

  assign rq  = ~req_s_q;
  assign bsy = ~busy_s_q;

  // Search starts just after the last winner, so it ends up last in line.
  always_comb begin
    winner  = last_q;
    cand    = last_q;
    any_req = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_q) + i) % NREQ);
      if (!any_req && rq[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      last_q        <= IDW'(NREQ - 1);
      owner_q       <= '0;
      grant_n_q     <= '1;
      owner_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      grant_n_q     <= grant_n_d;
      owner_valid_q <= owner_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!bsy && any_req) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (bsy)                                  state_d = ST_BUSY;
        else if (!rq[owner_q])                    state_d = ST_RELEASE;
        else if (cnt_q == CW'(ACK_TIMEOUT - 1))   state_d = ST_RELEASE;
      end
      ST_BUSY: begin
        if (!bsy) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the transition so that they are registered.
  always_comb begin
    grant_n_d     = '1;
    owner_d       = owner_q;
    owner_valid_d = (state_d == ST_GRANT) || (state_d == ST_BUSY);
    timeout_d     = 1'b0;
    last_d        = last_q;
    cnt_d         = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (((state_q == ST_GRANT) || (state_q == ST_BUSY)) && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_GRANT) begin
          owner_d           = winner;
          grant_n_d[winner] = 1'b0;
        end
      end
      ST_GRANT: begin
        if (state_d == ST_GRANT) grant_n_d[owner_q] = 1'b0;
        if ((state_d == ST_RELEASE) && rq[owner_q]) timeout_d = 1'b1;
      end
      ST_BUSY: begin
        // The counter saturates past this value, so the flag fires once per tenure.
        if ((state_d == ST_BUSY) && (cnt_q == CW'(HOLD_TIMEOUT - 1))) timeout_d = 1'b1;
      end
      ST_RELEASE: last_d = owner_q;
      default: ;
    endcase
  end

  assign bus.grant_n     = grant_n_q;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = owner_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Self-checking bench for xbus_arbiter: scenario tasks plus a grant scoreboard
// that pops the expected winner each time a new grant appears.
module tb_xbus_arbiter;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  xbus_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  xbus_arbiter #(
    .NREQ(4), .IDW(2), .CW(8), .ACK_TIMEOUT(8), .HOLD_TIMEOUT(20)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];

  logic [3:0] prev_grant = 4'hF;
  logic       busy_h1    = 1'b1;
  logic       busy_h2    = 1'b1;
  int         mon_idx, mon_zeros, mon_exp;

  // Scoreboard: every new grant is compared with the next queued winner.
  always @(negedge clk) begin
    if (reset_n && prev_grant == 4'hF && bus.grant_n != 4'hF) begin
      mon_idx = -1;
      mon_zeros = 0;
      for (int i = 0; i < 4; i++) begin
        if (bus.grant_n[i] == 1'b0) begin
          mon_idx = i;
          mon_zeros++;
        end
      end
      tests_run++;
      if (mon_zeros != 1) begin
        tests_failed++;
        $display("[TB] FAIL grant_onecold: got %b required one zero bit", bus.grant_n);
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL grant_unexpected: got grant to %0d required no grant", mon_idx);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_idx != mon_exp) begin
          tests_failed++;
          $display("[TB] FAIL grant_order: got %0d required %0d", mon_idx, mon_exp);
        end
      end
      tests_run++;
      if (busy_h1 === 1'b0 && busy_h2 === 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL grant_while_busy: got grant %b with busy_n low required none", bus.grant_n);
      end
    end
    busy_h2    = busy_h1;
    busy_h1    = bus.busy_n;
    prev_grant = bus.grant_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (bus.grant_n != 4'hF) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    bus.req_n  = 4'hF;
    bus.busy_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (bus.grant_n !== 4'hF) begin tests_failed++; $display("[TB] FAIL reset_grant: got %b required 1111", bus.grant_n); end
    tests_run++;
    if (bus.owner_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_owner_valid: got %b required 0", bus.owner_valid); end
    tests_run++;
    if (bus.timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_timeout: got %b required 0", bus.timeout); end
    tests_run++;
    if (bus.owner !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_owner: got %0d required 0", bus.owner); end
    reset_n = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (bus.grant_n !== 4'hF) begin tests_failed++; $display("[TB] FAIL idle_no_grant: got %b required 1111", bus.grant_n); end
  endtask

  task automatic test_single();
    bus.req_n = 4'b1110;
    exp_q.push_back(0);
    repeat (2) tick();
    tests_run++;
    if (bus.grant_n !== 4'hF) begin tests_failed++; $display("[TB] FAIL single_early: got %b required 1111", bus.grant_n); end
    tick();
    tests_run++;
    if (bus.grant_n !== 4'b1110) begin tests_failed++; $display("[TB] FAIL single_latency: got %b required 1110", bus.grant_n); end
    tests_run++;
    if (bus.owner_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_valid: got %b required 1", bus.owner_valid); end
    bus.busy_n = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (bus.grant_n !== 4'b1110) begin tests_failed++; $display("[TB] FAIL single_ack_early: got %b required 1110", bus.grant_n); end
    tick();
    tests_run++;
    if (bus.grant_n !== 4'hF) begin tests_failed++; $display("[TB] FAIL single_ack: got %b required 1111", bus.grant_n); end
    tests_run++;
    if (bus.owner !== 2'd0 || bus.owner_valid !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL single_busy_owner: got owner %0d valid %b required 0/1", bus.owner, bus.owner_valid);
    end
    bus.busy_n = 1'b1;
    bus.req_n  = 4'hF;
    repeat (2) tick();
    tests_run++;
    if (bus.owner_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_release_early: got valid %b required 1", bus.owner_valid); end
    tick();
    tests_run++;
    if (bus.owner_valid !== 1'b0 || bus.owner !== 2'd0) begin
      tests_failed++; $display("[TB] FAIL single_release: got owner %0d valid %b required 0/0", bus.owner, bus.owner_valid);
    end
    repeat (3) tick();
  endtask

  task automatic test_round_robin();
    int c;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req_n = 4'h0;
    for (int k = 0; k < 5; k++) exp_q.push_back(k % 4);
    for (int k = 0; k < 5; k++) begin
      wait_grant(20, c);
      tests_run++;
      if (c < 0) begin
        tests_failed++; $display("[TB] FAIL rr_wait: got no grant in 20 cycles required grant %0d", k % 4);
      end else begin
        tests_run++;
        if (bus.owner !== 2'(k % 4)) begin tests_failed++; $display("[TB] FAIL rr_owner: got %0d required %0d", bus.owner, k % 4); end
        bus.busy_n = 1'b0;
        repeat (3) tick();
        if (k == 4) bus.req_n = 4'hF;
        bus.busy_n = 1'b1;
      end
    end
    bus.req_n = 4'hF;
    repeat (6) tick();
  endtask

  task automatic test_ack_timeout();
    int c;
    int low_cnt;
    bus.req_n = 4'b1011;
    exp_q.push_back(2);
    wait_grant(10, c);
    tests_run++;
    if (c < 0) begin tests_failed++; $display("[TB] FAIL ack_wait: got no grant required grant 2"); end
    low_cnt = 1;
    bus.req_n = 4'b1001;
    exp_q.push_back(1);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.grant_n == 4'b1011) low_cnt++;
      else break;
    end
    tests_run++;
    if (low_cnt != 8) begin tests_failed++; $display("[TB] FAIL ack_grant_len: got %0d cycles required 8", low_cnt); end
    tests_run++;
    if (bus.timeout !== 1'b1) begin tests_failed++; $display("[TB] FAIL ack_timeout_pulse: got %b required 1", bus.timeout); end
    tick();
    tests_run++;
    if (bus.timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL ack_timeout_width: got %b required 0", bus.timeout); end
    wait_grant(10, c);
    tests_run++;
    if (bus.grant_n !== 4'b1101 || bus.owner !== 2'd1) begin
      tests_failed++; $display("[TB] FAIL ack_rotation: got grant %b owner %0d required 1101/1", bus.grant_n, bus.owner);
    end
    bus.req_n = 4'hF;
    repeat (6) tick();
  endtask

  task automatic test_hold_timeout();
    int c;
    int b;
    int t_idx;
    int pulses;
    bus.req_n = 4'b1101;
    exp_q.push_back(1);
    wait_grant(10, c);
    tests_run++;
    if (c < 0) begin tests_failed++; $display("[TB] FAIL hold_wait: got no grant required grant 1"); end
    bus.busy_n = 1'b0;
    bus.req_n  = 4'hF;
    b = -1; t_idx = -1; pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (b < 0 && bus.grant_n == 4'hF) b = i;
      if (bus.timeout) begin pulses++; t_idx = i; end
    end
    tests_run++;
    if (b != 3) begin tests_failed++; $display("[TB] FAIL hold_busy_entry: got cycle %0d required 3", b); end
    tests_run++;
    if (pulses != 1) begin tests_failed++; $display("[TB] FAIL hold_pulse_count: got %0d required 1", pulses); end
    tests_run++;
    if (t_idx - b != 20) begin tests_failed++; $display("[TB] FAIL hold_pulse_time: got %0d cycles after busy entry required 20", t_idx - b); end
    tests_run++;
    if (bus.owner_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_stays_busy: got valid %b required 1", bus.owner_valid); end
    bus.busy_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (bus.owner_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_release: got valid %b required 0", bus.owner_valid); end
    repeat (3) tick();
  endtask

  task automatic test_withdraw_foreign();
    int c;
    int rel;
    bus.busy_n = 1'b0;
    bus.req_n  = 4'b1110;
    repeat (6) tick();
    tests_run++;
    if (bus.grant_n !== 4'hF || bus.owner_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL foreign_busy: got grant %b valid %b required 1111/0", bus.grant_n, bus.owner_valid);
    end
    bus.busy_n = 1'b1;
    exp_q.push_back(0);
    wait_grant(10, c);
    tests_run++;
    if (bus.grant_n !== 4'b1110) begin tests_failed++; $display("[TB] FAIL foreign_after: got %b required 1110", bus.grant_n); end
    bus.req_n = 4'hF;
    rel = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.grant_n == 4'hF) begin rel = i; break; end
    end
    tests_run++;
    if (rel != 3) begin tests_failed++; $display("[TB] FAIL withdraw_latency: got %0d cycles required 3", rel); end
    tests_run++;
    if (bus.timeout !== 1'b0 || bus.owner_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL withdraw_release: got timeout %b valid %b required 0/0", bus.timeout, bus.owner_valid);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int c;
    bus.req_n = 4'b1011;
    exp_q.push_back(2);
    wait_grant(10, c);
    tests_run++;
    if (c < 0) begin tests_failed++; $display("[TB] FAIL mid_wait: got no grant required grant 2"); end
    bus.busy_n = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (bus.owner_valid !== 1'b1 || bus.owner !== 2'd2) begin
      tests_failed++; $display("[TB] FAIL mid_busy: got owner %0d valid %b required 2/1", bus.owner, bus.owner_valid);
    end
    reset_n = 1'b0;
    #2;
    tests_run++;
    if (bus.grant_n !== 4'hF || bus.owner_valid !== 1'b0 || bus.timeout !== 1'b0 || bus.owner !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL mid_async_reset: got grant %b valid %b timeout %b owner %0d required 1111/0/0/0",
               bus.grant_n, bus.owner_valid, bus.timeout, bus.owner);
    end
    bus.busy_n = 1'b1;
    bus.req_n  = 4'h0;
    tick();
    reset_n = 1'b1;
    exp_q.push_back(0);
    wait_grant(10, c);
    tests_run++;
    if (bus.owner !== 2'd0 || bus.grant_n !== 4'b1110) begin
      tests_failed++; $display("[TB] FAIL mid_priority: got grant %b owner %0d required 1110/0", bus.grant_n, bus.owner);
    end
    bus.req_n = 4'hF;
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ack_timeout();
    test_hold_timeout();
    test_withdraw_foreign();
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("[TB] FAIL scoreboard_drain: got %0d pending grants required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
